// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue: bundle layout, reset PC
// and the counter-width helper.
package if_pkg;

  localparam int IF_BUNDLE_W = 66;
  localparam int ADEF_BIT    = 0;
  localparam int PC_LSB      = 1;
  localparam int INST_LSB    = 33;
  localparam int PRED_BIT    = 65;

  localparam logic [31:0] PC_INIT_DEFAULT = 32'h1c00_0000;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/if_ibuf.sv
// Small synchronous FIFO with a combinational head. It is used both as the
// instruction buffer and as the tag queue holding the PCs of in-flight requests.
module if_ibuf
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = IF_BUNDLE_W
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem_reg[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && !clear && wr_ptr_reg == PTR_W'(gi)) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Pipelined instruction fetch: several SRAM requests in flight, buffered results
// ahead of ID, stale responses discarded after a redirect, ADEF on misaligned PC.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] PC_INIT         = PC_INIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   inst_sram_req,
  output logic [31:0]            inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic                   flush,
  input  logic [31:0]            flush_target,
  input  logic                   id_flush,
  input  logic [31:0]            id_flush_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IF_BUNDLE_W-1:0] out_bundle
);

  localparam int OS_W  = cnt_w(MAX_OUTSTANDING);
  localparam int BUF_W = cnt_w(IBUF_DEPTH);
  localparam int SUM_W = cnt_w(MAX_OUTSTANDING + IBUF_DEPTH);

  logic [31:0]            pc_reg, hold_addr_reg, target, tag_head;
  logic [OS_W-1:0]        os_cnt_reg, cn_cnt_reg, os_cnt_next;
  logic                   hold_reg, fault_reg;
  logic                   g_flush, fire, drop, data_push, adef_push, credit_ok, pc_aligned;
  logic [BUF_W-1:0]       buf_count;
  logic                   buf_full, buf_empty;
  logic [IF_BUNDLE_W-1:0] buf_head, push_bundle;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] unused_tag_count;
  logic                   unused_tag_full, unused_tag_empty;

  assign g_flush    = flush | id_flush;
  assign target     = flush ? flush_target : id_flush_target;
  assign pc_aligned = (pc_reg[1:0] == 2'b00);
  // Credit covers both buffered entries and responses still on their way.
  assign credit_ok  = (os_cnt_reg < OS_W'(MAX_OUTSTANDING)) &&
                      ((SUM_W'(os_cnt_reg) + SUM_W'(buf_count)) < SUM_W'(IBUF_DEPTH));

  assign inst_sram_req  = resetn & (hold_reg | (~fault_reg & pc_aligned & credit_ok));
  assign inst_sram_addr = hold_reg ? hold_addr_reg : pc_reg;
  assign fire           = inst_sram_req & inst_sram_addr_ok;
  assign os_cnt_next    = os_cnt_reg + OS_W'(fire) - OS_W'(inst_sram_data_ok);

  assign drop      = inst_sram_data_ok & (cn_cnt_reg != '0);
  assign data_push = inst_sram_data_ok & ~drop & ~g_flush;
  assign adef_push = ~fault_reg & ~pc_aligned & ~buf_full & ~g_flush & ~data_push;

  always_comb begin
    push_bundle = '0;
    if (data_push) begin
      push_bundle[INST_LSB +: 32] = inst_sram_rdata;
      push_bundle[PC_LSB +: 32]   = tag_head;
    end else begin
      push_bundle[PC_LSB +: 32]   = pc_reg;
      push_bundle[ADEF_BIT]       = 1'b1;
    end
  end

  assign out_valid  = ~buf_empty & ~g_flush;
  assign out_bundle = buf_empty ? '0 : buf_head;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_reg        <= PC_INIT;
      os_cnt_reg    <= '0;
      cn_cnt_reg    <= '0;
      hold_reg      <= 1'b0;
      hold_addr_reg <= '0;
      fault_reg     <= 1'b0;
    end else begin
      os_cnt_reg <= os_cnt_next;
      if (g_flush) begin
        pc_reg     <= target;
        fault_reg  <= 1'b0;
        cn_cnt_reg <= os_cnt_next;
      end else begin
        if (fire && !hold_reg) pc_reg <= pc_reg + 32'd4;
        if (adef_push) fault_reg <= 1'b1;
        // The held request was already cancelled when it was parked.
        cn_cnt_reg <= cn_cnt_reg - OS_W'(drop) + OS_W'(fire & hold_reg);
      end
      if (fire && hold_reg) begin
        hold_reg <= 1'b0;
      end else if (g_flush && inst_sram_req && !inst_sram_addr_ok) begin
        hold_reg      <= 1'b1;
        hold_addr_reg <= inst_sram_addr;
      end
    end
  end

  if_ibuf #(.DEPTH(IBUF_DEPTH), .WIDTH(IF_BUNDLE_W)) u_ibuf (
    .clk       (clk),
    .resetn    (resetn),
    .push      (data_push | adef_push),
    .push_data (push_bundle),
    .pop       (out_valid & out_ready),
    .clear     (g_flush),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Every accepted request, stale or not, gets a tag so responses stay aligned.
  if_ibuf #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_tag_q (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fire),
    .push_data (inst_sram_addr),
    .pop       (inst_sram_data_ok),
    .clear     (1'b0),
    .head      (tag_head),
    .count     (unused_tag_count),
    .full      (unused_tag_full),
    .empty     (unused_tag_empty)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: SRAM model, expected-bundle scoreboard, a vector
// table for the streaming/stall sequence and hand-written redirect cases.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam logic [31:0] PC0 = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        flush, id_flush, out_valid, out_ready;
  logic [31:0] flush_target, id_flush_target;
  logic [65:0] out_bundle;

  always #5 clk = ~clk;

  if_fetch_queue #(.MAX_OUTSTANDING(2), .IBUF_DEPTH(4), .PC_INIT(PC0)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .flush             (flush),
    .flush_target      (flush_target),
    .id_flush          (id_flush),
    .id_flush_target   (id_flush_target),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_bundle        (out_bundle)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [65:0] exp_q[$];
  logic [31:0] sram_q[$];
  logic [31:0] m_pc;
  logic        m_hold, m_fault, dok_en;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[18];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [65:0] mk(input logic [31:0] inst, input logic [31:0] pc, input logic adef);
    return {1'b0, inst, pc, adef};
  endfunction

  function automatic vec_t mkv(input logic rdy, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // One clock cycle: present SRAM response, sample mid-cycle, update the model.
  task automatic step();
    logic        fire, g;
    logic [31:0] tgt;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = '0;
    if (resetn && dok_en && sram_q.size() > 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem_word(sram_q[0]);
    end
    #2;
    if (!resetn) begin
      check("req_in_reset", 66'(inst_sram_req), 66'(0));
      sram_q.delete(); exp_q.delete();
      m_pc = PC0; m_hold = 1'b0; m_fault = 1'b0;
    end else begin
      fire = inst_sram_req & inst_sram_addr_ok;
      g    = flush | id_flush;
      tgt  = flush ? flush_target : id_flush_target;
      if (g) begin
        check("valid_masked", 66'(out_valid), 66'(0));
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL unexpected_out: got %h, expected no entry", out_bundle);
        end else begin
          check("bundle", out_bundle, exp_q.pop_front());
        end
      end
      if (inst_sram_data_ok) void'(sram_q.pop_front());
      if (fire) begin
        if (m_fault) check("req_during_fault", 66'(fire), 66'(0));
        if (!g && !m_hold) begin
          check("issue_addr", 66'(inst_sram_addr), 66'(m_pc));
          exp_q.push_back(mk(mem_word(m_pc), m_pc, 1'b0));
          m_pc = m_pc + 32'd4;
        end
        sram_q.push_back(inst_sram_addr);
        m_hold = 1'b0;
      end
      if (g) begin
        exp_q.delete();
        m_pc = tgt; m_fault = 1'b0;
        if (inst_sram_req && !inst_sram_addr_ok) m_hold = 1'b1;
        if (tgt[1:0] != 2'b00) begin
          m_fault = 1'b1;
          exp_q.push_back(mk(32'd0, tgt, 1'b1));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin step(); k++; end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL %s: got no out_valid, expected one within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    flush = 1'b0; id_flush = 1'b0; flush_target = '0; id_flush_target = '0;
    out_ready = 1'b1; dok_en = 1'b1;
    m_pc = PC0; m_hold = 1'b0; m_fault = 1'b0;

    vecs[0]  = mkv(1, 1, PC0 + 32'h00, 0, 32'h0);
    vecs[1]  = mkv(1, 1, PC0 + 32'h04, 0, 32'h0);
    vecs[2]  = mkv(1, 1, PC0 + 32'h08, 1, PC0 + 32'h00);
    vecs[3]  = mkv(0, 1, PC0 + 32'h0c, 1, PC0 + 32'h04);
    vecs[4]  = mkv(0, 1, PC0 + 32'h10, 1, PC0 + 32'h04);
    for (int i = 5; i < 13; i++) vecs[i] = mkv(0, 0, 32'h0, 1, PC0 + 32'h04);
    vecs[13] = mkv(1, 0, 32'h0, 1, PC0 + 32'h04);
    vecs[14] = mkv(1, 1, PC0 + 32'h14, 1, PC0 + 32'h08);
    vecs[15] = mkv(1, 1, PC0 + 32'h18, 1, PC0 + 32'h0c);
    vecs[16] = mkv(1, 1, PC0 + 32'h1c, 1, PC0 + 32'h10);
    vecs[17] = mkv(1, 1, PC0 + 32'h20, 1, PC0 + 32'h14);

    // Reset state
    run(2);
    check("rst_req", 66'(inst_sram_req), 66'(0));
    check("rst_valid", 66'(out_valid), 66'(0));
    check("rst_bundle", out_bundle, 66'(0));
    resetn = 1'b1;

    // Zero-wait streaming, then a 10-cycle ID stall and release
    for (int i = 0; i < 18; i++) begin
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_req", i), 66'(inst_sram_req), 66'(vecs[i].exp_req));
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), 66'(inst_sram_addr), 66'(vecs[i].exp_addr));
      check($sformatf("vec%0d_valid", i), 66'(out_valid), 66'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), 66'(out_bundle[PC_LSB +: 32]), 66'(vecs[i].exp_pc));
      step();
    end

    // Two requests in flight, then flush: both responses dropped
    out_ready = 1'b1; dok_en = 1'b0;
    run(4);
    check("inflight_cnt", 66'(sram_q.size()), 66'(2));
    check("inflight_req_off", 66'(inst_sram_req), 66'(0));
    flush = 1'b1; flush_target = 32'h1c00_0100; dok_en = 1'b1;
    step();
    flush = 1'b0;
    wait_valid("flush_wait", 20);
    check("flush_pc", 66'(out_bundle[PC_LSB +: 32]), 66'(32'h1c00_0100));
    check("flush_inst", 66'(out_bundle[INST_LSB +: 32]), 66'(mem_word(32'h1c00_0100)));

    // id_flush while a request waits for addr_ok
    inst_sram_addr_ok = 1'b0;
    run(2);
    check("hold_pre_req", 66'(inst_sram_req), 66'(1));
    begin
      logic [31:0] a;
      a = inst_sram_addr;
      id_flush = 1'b1; id_flush_target = 32'h1c00_0200;
      step();
      id_flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("hold_req", 66'(inst_sram_req), 66'(1));
        check("hold_addr", 66'(inst_sram_addr), 66'(a));
        step();
      end
      inst_sram_addr_ok = 1'b1;
      check("hold_addr_final", 66'(inst_sram_addr), 66'(a));
      step();
    end
    check("post_hold_req", 66'(inst_sram_req), 66'(1));
    check("post_hold_addr", 66'(inst_sram_addr), 66'(32'h1c00_0200));
    wait_valid("hold_wait", 20);
    check("post_hold_pc", 66'(out_bundle[PC_LSB +: 32]), 66'(32'h1c00_0200));

    // Misaligned redirect produces one ADEF entry and stops fetching
    out_ready = 1'b0;
    id_flush = 1'b1; id_flush_target = 32'h1c00_0102;
    step();
    id_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("adef_req_off", 66'(inst_sram_req), 66'(0));
      step();
    end
    check("adef_valid", 66'(out_valid), 66'(1));
    check("adef_bundle", out_bundle, mk(32'd0, 32'h1c00_0102, 1'b1));
    flush = 1'b1; flush_target = 32'h1c00_8000;
    step();
    flush = 1'b0; out_ready = 1'b1;
    check("resume_req", 66'(inst_sram_req), 66'(1));
    check("resume_addr", 66'(inst_sram_addr), 66'(32'h1c00_8000));

    // flush and id_flush together while data_ok returns
    run(5);
    check("dok_pending", 66'(sram_q.size() != 0), 66'(1));
    flush = 1'b1; flush_target = 32'h1c00_a000;
    id_flush = 1'b1; id_flush_target = 32'h1c00_b000;
    step();
    flush = 1'b0; id_flush = 1'b0;
    check("both_addr", 66'(inst_sram_addr), 66'(32'h1c00_a000));
    wait_valid("both_wait", 20);
    check("both_pc", 66'(out_bundle[PC_LSB +: 32]), 66'(32'h1c00_a000));

    // Reset mid-stream
    run(3);
    resetn = 1'b0;
    step();
    check("mid_rst_req", 66'(inst_sram_req), 66'(0));
    check("mid_rst_valid", 66'(out_valid), 66'(0));
    check("mid_rst_bundle", out_bundle, 66'(0));
    resetn = 1'b1;
    #1;
    check("post_rst_req", 66'(inst_sram_req), 66'(1));
    check("post_rst_addr", 66'(inst_sram_addr), 66'(PC0));
    run(6);

    // Drain: stop accepting and let everything reach ID
    inst_sram_addr_ok = 1'b0;
    run(10);
    check("drained", 66'(exp_q.size()), 66'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage. It keeps up to MAX_OUTSTANDING instruction-SRAM requests in flight over the addr_ok/data_ok handshake and buffers returned instructions in an IBUF_DEPTH-entry FIFO ahead of ID. It handles flush and redirect with in-flight requests by counting and discarding stale responses, and reports misaligned-PC faults (ADEF) without issuing a bus request. It sits between the core top (instruction SRAM interface) and ID, and replaces the single-request IF stage.

## Interface
Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered SRAM requests (≥1).
- IBUF_DEPTH, 4, instruction buffer entries (≥MAX_OUTSTANDING, power of two).
- PC_INIT, 32'h1c000000, PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- inst_sram_req  out  1  request valid; forced 0 while resetn=0.
- inst_sram_addr  out  32  request address; stable while req=1 and addr_ok=0.
- inst_sram_addr_ok  in  1  request accepted this cycle (req & addr_ok).
- inst_sram_data_ok  in  1  oldest accepted request returns data this cycle (in order).
- inst_sram_rdata  in  32  returned instruction.
- flush  in  1  exception/ertn redirect; highest priority.
- flush_target  in  32  redirect PC for flush.
- id_flush  in  1  branch redirect from ID.
- id_flush_target  in  32  redirect PC for id_flush.
- out_valid  out  1  buffer head valid, masked by flush|id_flush.
- out_ready  in  1  ID allowin.
- out_bundle  out  66  {predict(=0), inst[31:0], pc[31:0], adef}.

## Operation
- State: pc, outstanding count (os_cnt), cancel count (cn_cnt), hold flag plus hold_addr, fault flag, FIFO. Counter width $clog2(MAX_OUTSTANDING+1).
- Issue condition: req=1 when ~fault, pc[1:0]==0, os_cnt<MAX_OUTSTANDING, and os_cnt+fifo_count<IBUF_DEPTH. It is also 1 whenever hold=1. Credit is reserved at issue, so the FIFO can never overflow.
- Address: inst_sram_addr = hold ? hold_addr : pc. On req&addr_ok with hold=0, pc <= pc+4 and os_cnt increments.
- Misaligned pc (pc[1:0]≠0, ~fault, FIFO not full): no bus request. Push {0, 0, pc, 1} into the FIFO and set fault. Fault blocks issue until the next flush or id_flush.
- data_ok: os_cnt decrements. If cn_cnt>0, the data is dropped and cn_cnt decrements. Otherwise push {0, rdata, pc_of_req, 0}. A PC queue parallel to the requests, or the FIFO tail tagging, supplies pc_of_req.
- Pop: out_valid & out_ready.
- Redirect (g_flush = flush|id_flush; target = flush ? flush_target : id_flush_target):
  - pc <= target; FIFO cleared; fault cleared.
  - cn_cnt <= os_cnt_next, the count after this cycle's addr_ok/data_ok, with any surviving data_ok this cycle dropped.
  - If req=1 and addr_ok=0 this cycle: hold <= 1, hold_addr <= current address. The held request stays asserted; its addr_ok increments os_cnt and cn_cnt and clears hold, without advancing pc.
  - New-path issue resumes the cycle after hold clears.
- Redirect while hold=1 only retargets pc; the held request is already marked cancelled.
- Empty FIFO with out_ready: no effect. Pop and push in the same cycle are legal at any occupancy.

## Timing
- Reset (resetn=0 at an edge):
  - pc=PC_INIT; os_cnt=cn_cnt=0; hold=fault=0; FIFO empty.
  - out_valid=0, out_bundle=0, inst_sram_req=0.
  - inst_sram_req may rise in the first cycle with resetn=1.
- Reset mid-operation discards all in-flight state. Data_ok responses after reset for pre-reset requests are not supported; the SRAM is reset together with the core.
- Latency: req&addr_ok at cycle N; earliest data_ok at N+1; out_valid at the cycle after data_ok.
- Back-to-back issue: one request per cycle while credit allows.
- Redirect at cycle N: out_valid=0 in cycle N (masked). First new-path request at N+1 if not holding. Stale responses are never presented.
- Simultaneous flush and id_flush: flush_target wins.

## Structure
- Shared package if_pkg:
  - IF_BUNDLE_W=66 and bundle field offsets (ADEF_BIT=0, PC_LSB=1, INST_LSB=33, PRED_BIT=65).
  - PC_INIT default.
  - Width helper for counters.
- One sub-module: if_ibuf, a synchronous FIFO (push, pop, clear, count, full, empty), parameter DEPTH and WIDTH=IF_BUNDLE_W.
- The outstanding-PC tag queue is a second if_ibuf instance with DEPTH=MAX_OUTSTANDING and WIDTH=32.

## Test plan
- Reset then zero-wait SRAM (addr_ok=1, data_ok one cycle later): pcs 1c000000, 1c000004, 1c000008 appear in order on out_bundle, one per cycle, with out_ready=1.
- out_ready=0 for 10 cycles, MAX_OUTSTANDING=2, IBUF_DEPTH=4: req deasserts once os_cnt+count=4. FIFO holds 4 entries. No loss when out_ready=1.
- Two requests in flight, flush with target 1c000100: both responses dropped (cn_cnt 2→0). Next presented pc=1c000100.
- id_flush while req=1 and addr_ok=0 for 3 cycles: addr stays at the old pc until addr_ok. That response is dropped. Next request addr = id_flush_target.
- id_flush_target=1c000102: no req issued. One entry with adef=1, pc=1c000102, inst=0. req stays 0 until flush to 1c008000 resumes fetch.
- flush and id_flush in the same cycle as data_ok: data dropped. pc=flush_target. resetn=0 mid-stream: all outputs return to reset values next cycle.
